// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state codes,
// ALU op codes and the packed records passed between arbiter and ALU.
package alu_arbiter_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] data_t;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // ALU op encoding.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Operation captured from the granted requester.
  typedef struct packed {
    data_t a;
    data_t b;
    logic  op;
    logic  id;
  } operand_t;

  // Combinational ALU result bundle.
  typedef struct packed {
    data_t result;
    logic  cout;
    logic  zero;
  } alu_out_t;

  function automatic logic is_zero(input data_t v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and the
// response consumer. The slave modport is the arbiter's view.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic  req0_valid;
  logic  req0_ready;
  data_t req0_a;
  data_t req0_b;
  logic  req0_op;

  logic  req1_valid;
  logic  req1_ready;
  data_t req1_a;
  data_t req1_b;
  logic  req1_op;

  logic  rsp_valid;
  logic  rsp_ready;
  logic  rsp_id;
  data_t rsp_result;
  logic  rsp_cout;
  logic  rsp_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero,
    output rsp_ready
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared 16-bit add/subtract unit. Subtraction is a + ~b + 1, so cout=1
// means "no borrow". Purely combinational.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  data_t    a,
  input  data_t    b,
  input  logic     op,
  output alu_out_t out
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] b_eff;
  logic              carry_in;

  // One adder serves both ops: invert b and inject a carry for SUB.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    carry_in   = (op == OP_SUB);
    b_eff      = carry_in ? ~b : b;
    sum        = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, carry_in};
    out.result = sum[DATA_W-1:0];
    out.cout   = sum[DATA_W];
    out.zero   = is_zero(sum[DATA_W-1:0]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU. One operation in
// flight at a time: IDLE accepts, EXEC computes from captured operands,
// HOLD presents the registered response until the consumer takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int RR_EN = 1  // 1: round-robin on ties, 0: requester 0 always wins
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       last_grant_q;
  logic       grant_id;
  logic       accept;
  logic       any_valid;
  operand_t   grant_opnd;
  operand_t   opnd_q;
  alu_out_t   alu_out;

  data_t      rsp_result_q;
  logic       rsp_cout_q;
  logic       rsp_zero_q;
  logic       rsp_id_q;

  // Pick the requester to serve this cycle; ready is also held off during reset.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (RR_EN != 0) begin
      grant_id = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    end else begin
      grant_id = ~bus.req0_valid;
    end
    accept = rst_n && (state_q == ST_IDLE) && any_valid;
  end

  assign bus.req0_ready = accept && (grant_id == 1'b0);
  assign bus.req1_ready = accept && (grant_id == 1'b1);

  // Operand bundle of whichever requester is granted.
  always_comb begin
    if (grant_id) begin
      grant_opnd = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op, id: 1'b1};
    end else begin
      grant_opnd = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op, id: 1'b0};
    end
  end

  // FSM next-state: the HOLD exit is the only place rsp_ready is looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the granted operation and remember who won, only on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand registers are reset so a discarded operation leaves no stale data behind.
    if (!rst_n) begin
      opnd_q       <= '0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      opnd_q       <= grant_opnd;
      last_grant_q <= grant_id;
    end
  end

  alu_arbiter_alu u_alu (
    .a   (opnd_q.a),
    .b   (opnd_q.b),
    .op  (opnd_q.op),
    .out (alu_out)
  );

  // Register the ALU result at the end of EXEC; it then holds through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_result_q <= alu_out.result;
      rsp_cout_q   <= alu_out.cout;
      rsp_zero_q   <= alu_out.zero;
      rsp_id_q     <= opnd_q.id;
    end
  end

  // Valid follows the state directly, so reset drops it without waiting for a clock.
  assign bus.rsp_valid  = (state_q == ST_HOLD);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority
// instance are driven with identical stimulus and checked side by side.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  data_t req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic  req0_op = 1'b0, req1_op = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_arbiter_if ifc_rr ();
  alu_arbiter_if ifc_fp ();

  assign ifc_rr.req0_valid = req0_valid;
  assign ifc_rr.req0_a     = req0_a;
  assign ifc_rr.req0_b     = req0_b;
  assign ifc_rr.req0_op    = req0_op;
  assign ifc_rr.req1_valid = req1_valid;
  assign ifc_rr.req1_a     = req1_a;
  assign ifc_rr.req1_b     = req1_b;
  assign ifc_rr.req1_op    = req1_op;
  assign ifc_rr.rsp_ready  = rsp_ready;

  assign ifc_fp.req0_valid = req0_valid;
  assign ifc_fp.req0_a     = req0_a;
  assign ifc_fp.req0_b     = req0_b;
  assign ifc_fp.req0_op    = req0_op;
  assign ifc_fp.req1_valid = req1_valid;
  assign ifc_fp.req1_a     = req1_a;
  assign ifc_fp.req1_b     = req1_b;
  assign ifc_fp.req1_op    = req1_op;
  assign ifc_fp.rsp_ready  = rsp_ready;

  alu_arbiter #(.RR_EN(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(ifc_rr));
  alu_arbiter #(.RR_EN(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(ifc_fp));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Response fields on both instances.
  task automatic check_rsp(input string tag, input data_t r, input logic c, input logic z,
                           input logic id);
    check({tag, " rr valid"},  ifc_rr.rsp_valid,  1);
    check({tag, " rr result"}, ifc_rr.rsp_result, r);
    check({tag, " rr cout"},   ifc_rr.rsp_cout,   c);
    check({tag, " rr zero"},   ifc_rr.rsp_zero,   z);
    check({tag, " rr id"},     ifc_rr.rsp_id,     id);
    check({tag, " fp valid"},  ifc_fp.rsp_valid,  1);
    check({tag, " fp result"}, ifc_fp.rsp_result, r);
    check({tag, " fp id"},     ifc_fp.rsp_id,     id);
  endtask

  // Single uncontended operation with exact latency checks.
  task automatic run_op(input string tag, input logic id, input data_t a, input data_t b,
                        input logic op, input data_t er, input logic ec, input logic ez);
    @(negedge clk);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    #1;
    check({tag, " rr own ready"},   id ? ifc_rr.req1_ready : ifc_rr.req0_ready, 1);
    check({tag, " rr other ready"}, id ? ifc_rr.req0_ready : ifc_rr.req1_ready, 0);
    check({tag, " fp own ready"},   id ? ifc_fp.req1_ready : ifc_fp.req0_ready, 1);
    @(posedge clk); #1;
    // Drop valid and scramble the operands: the captured copy must win.
    if (id) begin req1_valid = 0; req1_a = ~req1_a; req1_b = req1_b + 16'd7; req1_op = ~req1_op; end
    else    begin req0_valid = 0; req0_a = ~req0_a; req0_b = req0_b + 16'd7; req0_op = ~req0_op; end
    @(negedge clk);
    check({tag, " exec rsp_valid"}, ifc_rr.rsp_valid, 0);
    @(negedge clk);
    check_rsp(tag, er, ec, ez, id);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    check({tag, " after hs rsp_valid"}, ifc_rr.rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          got;
    logic [3:0]  ids_rr, ids_fp;

    // Reset values, with a requester pending during reset.
    req0_valid = 1;
    #12;
    check("reset req0_ready",  ifc_rr.req0_ready, 0);
    check("reset rsp_valid",   ifc_rr.rsp_valid,  0);
    check("reset rsp_result",  ifc_rr.rsp_result, 0);
    check("reset rsp_id",      ifc_rr.rsp_id,     0);
    check("reset rsp_cout",    ifc_rr.rsp_cout,   0);
    check("reset rsp_zero",    ifc_rr.rsp_zero,   0);
    @(negedge clk);
    req0_valid = 0;
    rst_n = 1;

    // Simple ADD from requester 0.
    run_op("add", 1'b0, 16'h0003, 16'h0004, OP_ADD, 16'h0007, 1'b0, 1'b0);

    // SUB to zero from requester 1 with a stalled consumer.
    @(negedge clk);
    req1_valid = 1; req1_a = 16'h1234; req1_b = 16'h1234; req1_op = OP_SUB;
    #1;
    check("stall req1_ready", ifc_rr.req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 0; req1_a = 16'h0000;
    rsp_ready = 1;  // asserted during EXEC: must be ignored
    @(negedge clk);
    check("stall exec rsp_valid", ifc_rr.rsp_valid, 0);
    @(posedge clk); #1;
    rsp_ready = 0;
    req0_valid = 1; req0_a = 16'h00AA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_rsp($sformatf("stall c%0d", i), 16'h0000, 1'b1, 1'b1, 1'b1);
      check($sformatf("stall c%0d req0_ready", i), ifc_rr.req0_ready, 0);
    end
    req0_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall post c%0d rsp_valid", i), ifc_rr.rsp_valid, 0);
    end

    // Overflow and borrow.
    run_op("ovf", 1'b0, 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b1);
    run_op("brw", 1'b1, 16'h0000, 16'h0001, OP_SUB, 16'hFFFF, 1'b0, 1'b0);

    // Contention: both requesters valid for four operations (last grant was 1).
    @(negedge clk);
    req0_valid = 1; req0_a = 16'd1; req0_b = 16'd1; req0_op = OP_ADD;
    req1_valid = 1; req1_a = 16'd5; req1_b = 16'd5; req1_op = OP_ADD;
    rsp_ready = 1;
    got = 0; ids_rr = '0; ids_fp = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (ifc_rr.rsp_valid) begin
        ids_rr[got] = ifc_rr.rsp_id;
        ids_fp[got] = ifc_fp.rsp_id;
        check($sformatf("cont%0d fp valid", got), ifc_fp.rsp_valid, 1);
        check($sformatf("cont%0d rr result", got), ifc_rr.rsp_result,
              ifc_rr.rsp_id ? 16'd10 : 16'd2);
        check($sformatf("cont%0d fp result", got), ifc_fp.rsp_result, 16'd2);
        got++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    rsp_ready = 0;
    check("cont responses", got, 4);
    check("cont rr id seq", ids_rr, 4'b1010);
    check("cont fp id seq", ids_fp, 4'b0000);

    // Reset while holding a response granted to requester 0.
    @(negedge clk);
    req0_valid = 1; req0_a = 16'h00FF; req0_b = 16'h0001; req0_op = OP_ADD;
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst hold rsp_valid", ifc_rr.rsp_valid, 1);
    check("rst hold result",    ifc_rr.rsp_result, 16'h0100);
    rst_n = 0;
    req1_valid = 1;
    #1;
    check("rst rr rsp_valid drop", ifc_rr.rsp_valid, 0);
    check("rst fp rsp_valid drop", ifc_fp.rsp_valid, 0);
    check("rst req1_ready",        ifc_rr.req1_ready, 0);
    check("rst rsp_result",        ifc_rr.rsp_result, 0);
    @(negedge clk);
    req1_valid = 0;
    rst_n = 1;
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post rst c%0d rsp_valid", i), ifc_rr.rsp_valid, 0);
    end
    rsp_ready = 0;
    req0_valid = 1; req0_a = 16'h0002; req0_b = 16'h0003; req0_op = OP_ADD;
    req1_valid = 1; req1_a = 16'h0009; req1_b = 16'h0001; req1_op = OP_SUB;
    #1;
    check("post rst tie req0_ready", ifc_rr.req0_ready, 1);
    check("post rst tie req1_ready", ifc_rr.req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check_rsp("post rst", 16'h0005, 1'b0, 1'b0, 1'b0);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin grant, 0 = fixed priority to requester 0.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester k has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester k's operation is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  16  operands.
REQ-007 SHALL have ports req0_op / req1_op  input  1  0 = ADD, 1 = SUB (a - b).
REQ-008 SHALL have port rsp_valid  output  1  response held on rsp_* outputs.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-011 SHALL have ports rsp_result  output  16, rsp_cout  output  1, rsp_zero  output  1  registered ALU result, carry-out, zero flag.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-013 IDLE: if any reqk_valid, SHALL grant exactly one requester, assert its reqk_ready combinationally in that cycle, capture a/b/op/id into operand registers, go to EXEC; else stay IDLE.
REQ-014 reqk_ready SHALL be 0 in EXEC and HOLD, and 0 for the non-granted requester.
REQ-015 Grant with RR_EN=1: if one valid, grant it; if both valid, grant the one not granted last (last_grant register, updated only on an accept).
REQ-016 Grant with RR_EN=0: requester 0 wins whenever req0_valid=1.
REQ-017 EXEC: shared alu SHALL be driven from the operand registers only; result, cout and zero registered into rsp_* at the end of the cycle; go to HOLD.
REQ-018 HOLD: rsp_valid=1; rsp_* SHALL remain stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-019 Latency: accept in cycle N -> rsp_valid first high in cycle N+2; minimum 3 cycles per operation (no accept in the HOLD handshake cycle).
REQ-020 Arithmetic SHALL be 16-bit modular; rsp_cout = carry out of a + b (ADD) or a + ~b + 1 (SUB, 1 = no borrow); rsp_zero = 1 iff rsp_result == 0.
REQ-021 Requester inputs changing while not granted SHALL have no effect; operands captured on accept SHALL be unaffected by later input changes.
REQ-022 rsp_ready asserted outside HOLD SHALL be ignored.
REQ-023 SHALL never drop or duplicate an accepted operation; each accept produces exactly one response.

Reset
REQ-024 On rst_n=0 (asynchronous), state=IDLE, last_grant=1 (so requester 0 wins the first tie), operand registers=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0, rsp_zero=0.
REQ-025 Reset mid-operation (EXEC or HOLD) SHALL discard the in-flight operation with no response; reqk_ready SHALL be 0 while rst_n=0.

Structure
REQ-026 State encoding (IDLE/EXEC/HOLD) and op encoding constants (OP_ADD=0, OP_SUB=1) SHALL live in a shared package used by the alu and arbiter.
REQ-027 SHALL instantiate exactly one existing alu sub-module; no other arithmetic logic.

Verification
REQ-028 Single ADD: req0 a=0x0003 b=0x0004 op=0 at cycle N -> req0_ready at N, rsp_valid at N+2, rsp_result=0x0007, cout=0, zero=0, id=0.
REQ-029 SUB to zero with stalled consumer: req1 a=0x1234 b=0x1234 op=1, rsp_ready held 0 for 5 cycles -> rsp_result=0x0000, cout=1, zero=1, id=1 stable through stall; single handshake.
REQ-030 Overflow/borrow: a=0xFFFF b=0x0001 ADD -> 0x0000, cout=1, zero=1; a=0x0000 b=0x0001 SUB -> 0xFFFF, cout=0, zero=0.
REQ-031 Contention, RR_EN=1: both valid continuously for 4 operations -> rsp_id sequence 0,1,0,1; RR_EN=0 -> 0,0,0,0.
REQ-032 Reset in HOLD: assert rst_n=0 while rsp_valid=1 -> rsp_valid drops immediately, no response after release, next tie grants requester 0.
